// File: rtl/imem_loader.sv
// Instruction-memory loader/responder: streams a program image in, then serves fetches.
// Optional bounds-error reporting is enabled by defining IMEM_LOADER_OOB_CHECK_EN.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] TEXT_START = 32'h0000_3000,
  parameter logic [31:0] END_INSN   = 32'h0000_0073
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_start_i,
  input  logic [31:0]           load_data_i,
  input  logic                  load_valid_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  input  logic [31:0]           imem_addr_i,
  output logic [31:0]           imem_rdata_o,
  input  logic                  retire_valid_i,
  input  logic [31:0]           retire_insn_i,
  output logic                  fetch_enable_o,
  output logic                  prog_end_o,
  output logic                  oob_err_o,
  output logic                  load_ovf_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   num_words_o,
  output logic [31:0]           cycles_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   num_words_q, num_words_d;
  logic [31:0]           cycles_q, cycles_d;
  logic                  prog_end_q, prog_end_d;
  logic                  oob_err_q, oob_err_d;
  logic                  load_ovf_q, load_ovf_d;
  logic                  mem_we;

  logic [31:0] mem [Depth];
  logic [31:0] off;
  logic        in_range;
  logic [31:0] rd_word;

  // Addresses below TEXT_START wrap to a huge offset and fail the bound.
  assign off      = imem_addr_i - TEXT_START;
  assign in_range = (off[1:0] == 2'b00) &&
                    (off[31:2] < {{(29 - ADDR_WIDTH){1'b0}}, num_words_q});
  assign rd_word  = mem[off[ADDR_WIDTH+1:2]];

  assign load_ready_o   = (state_q == StLoad);
  assign fetch_enable_o = (state_q == StRun);
  assign done_o         = (state_q == StDone);
  assign imem_rdata_o   = (fetch_enable_o && in_range) ? rd_word : 32'h0;
  assign prog_end_o     = prog_end_q;
  assign oob_err_o      = oob_err_q;
  assign load_ovf_o     = load_ovf_q;
  assign num_words_o    = num_words_q;
  assign cycles_o       = cycles_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    num_words_d = num_words_q;
    cycles_d    = cycles_q;
    prog_end_d  = prog_end_q;
    oob_err_d   = oob_err_q;
    load_ovf_d  = load_ovf_q;
    mem_we      = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (load_start_i) begin
          state_d     = StLoad;
          wr_ptr_d    = '0;
          num_words_d = '0;
          cycles_d    = '0;
          prog_end_d  = 1'b0;
          oob_err_d   = 1'b0;
          load_ovf_d  = 1'b0;
        end
      end
      StLoad: begin
        if (load_valid_i) begin
          mem_we      = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          num_words_d = num_words_q + 1'b1;
          if (load_last_i) begin
            state_d = StRun;
          end else if (&wr_ptr_q) begin
            // Image full without a last marker: close it out as overflowed.
            load_ovf_d = 1'b1;
            state_d    = StRun;
          end
        end
      end
      StRun: begin
        if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        if (in_range && (imem_rdata_o == END_INSN)) prog_end_d = 1'b1;
`ifdef IMEM_LOADER_OOB_CHECK_EN
        // Past the end marker, out-of-range fetches are wrong-path and benign.
        if (!in_range && !prog_end_q) begin
          oob_err_d = 1'b1;
          state_d   = StDone;
        end
`endif
        if (retire_valid_i && (retire_insn_i == END_INSN)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      num_words_q <= '0;
      cycles_q    <= '0;
      prog_end_q  <= 1'b0;
      oob_err_q   <= 1'b0;
      load_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      num_words_q <= num_words_d;
      cycles_q    <= cycles_d;
      prog_end_q  <= prog_end_d;
      oob_err_q   <= oob_err_d;
      load_ovf_q  <= load_ovf_d;
    end
  end

  // Image storage is never reset so a reset keeps the last loaded program.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) mem[wr_ptr_q] <= load_data_i;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads/runs checked against a
// behavioural image model every cycle, plus literal spot checks.
module tb_imem_loader;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] TS    = 32'h0000_3000;
  localparam logic [31:0] EI    = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_start = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic [31:0] imem_addr = TS;
  logic [31:0] imem_rdata;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_insn = '0;
  logic        fetch_enable, prog_end, oob_err, load_ovf, done;
  logic [AW:0] num_words;
  logic [31:0] cycles;

  int checks = 0;
  int errors = 0;

  imem_loader #(
    .ADDR_WIDTH(AW),
    .TEXT_START(TS),
    .END_INSN  (EI)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .load_start_i  (load_start),
    .load_data_i   (load_data),
    .load_valid_i  (load_valid),
    .load_last_i   (load_last),
    .load_ready_o  (load_ready),
    .imem_addr_i   (imem_addr),
    .imem_rdata_o  (imem_rdata),
    .retire_valid_i(retire_valid),
    .retire_insn_i (retire_insn),
    .fetch_enable_o(fetch_enable),
    .prog_end_o    (prog_end),
    .oob_err_o     (oob_err),
    .load_ovf_o    (load_ovf),
    .done_o        (done),
    .num_words_o   (num_words),
    .cycles_o      (cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  int          m_n = 0;
  bit          m_valid = 0, m_load = 0, m_run = 0, m_done = 0;
  bit          m_pend = 0, m_oob = 0, m_ovf = 0;
  logic [31:0] m_cyc = '0;

  function automatic bit m_inr(input logic [31:0] a);
    logic [31:0] o;
    o = a - TS;
    return (o % 4 == 0) && ((o / 4) < m_n);
  endfunction

  function automatic logic [31:0] m_fetch(input logic [31:0] a);
    logic [31:0] o;
    o = a - TS;
    if (!m_run || !m_inr(a)) return 32'h0;
    return m_mem[o / 4];
  endfunction

  always @(posedge clk) begin
    logic [31:0] f;
    bit          inr, old_pend;
    f        = m_fetch(imem_addr);
    inr      = m_inr(imem_addr);
    old_pend = m_pend;
    if (rst) begin
      m_valid = 1; m_load = 0; m_run = 0; m_done = 0;
      m_n = 0; m_pend = 0; m_oob = 0; m_ovf = 0; m_cyc = '0;
    end else if (m_load) begin
      if (load_valid) begin
        m_mem[m_n] = load_data;
        m_n++;
        if (load_last || m_n == DEPTH) begin
          m_load = 0; m_run = 1; m_ovf = !load_last;
        end
      end
    end else if (m_run) begin
      if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
      if (inr && f == EI) m_pend = 1;
`ifdef IMEM_LOADER_OOB_CHECK_EN
      if (!inr && !old_pend) begin m_oob = 1; m_run = 0; m_done = 1; end
`endif
      if (retire_valid && retire_insn == EI) begin m_run = 0; m_done = 1; end
    end else if (load_start) begin
      m_load = 1; m_done = 0; m_n = 0;
      m_pend = 0; m_oob = 0; m_ovf = 0; m_cyc = '0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("load_ready", {31'b0, load_ready}, {31'b0, m_load});
      chk("fetch_enable", {31'b0, fetch_enable}, {31'b0, m_run});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("imem_rdata", imem_rdata, m_fetch(imem_addr));
      chk("prog_end", {31'b0, prog_end}, {31'b0, m_pend});
      chk("oob_err", {31'b0, oob_err}, {31'b0, m_oob});
      chk("load_ovf", {31'b0, load_ovf}, {31'b0, m_ovf});
      chk("num_words", {29'b0, num_words}, m_n);
      chk("cycles", cycles, m_cyc);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] img [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic load(input int n, input bit set_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        load_valid = 1'b0;
        tick();
      end
      load_valid = 1'b1;
      load_data  = img[i];
      load_last  = set_last && (i == n - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic retire_end();
    retire_valid = 1'b1;
    retire_insn  = EI;
    tick();
    retire_valid = 1'b0;
  endtask

  task automatic run_oob(input int n, input logic [31:0] a);
    imem_addr = TS;
    start();
    img[0] = 32'h13; img[1] = 32'h93; img[2] = 32'h113; img[3] = 32'h193;
    load(n, 1'b1, 1'b0);
    imem_addr = a;
    #1;
    chk("oob_rdata_zero", imem_rdata, 32'h0);
    tick();
`ifdef IMEM_LOADER_OOB_CHECK_EN
    chk("oob_flag", {31'b0, oob_err}, 32'd1);
    chk("oob_done", {31'b0, done}, 32'd1);
`else
    chk("oob_flag_off", {31'b0, oob_err}, 32'd0);
    chk("oob_still_run", {31'b0, fetch_enable}, 32'd1);
    imem_addr = TS;
    retire_end();
`endif
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_fetch_en", {31'b0, fetch_enable}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rdata", imem_rdata, 32'd0);

    // Load 4 words ending in ecall, run, wrong-path fetch after end
    start();
    img[0] = 32'h13; img[1] = 32'h0010_0093; img[2] = 32'h0020_0113; img[3] = EI;
    load(4, 1'b1, 1'b0);
    chk("t1_num_words", {29'b0, num_words}, 32'd4);
    chk("t1_fetch_en", {31'b0, fetch_enable}, 32'd1);
    #1;
    chk("t1_word0", imem_rdata, 32'h13);
    imem_addr = 32'h300C;
    #1;
    chk("t1_word3", imem_rdata, 32'h73);
    tick();
    chk("t1_prog_end", {31'b0, prog_end}, 32'd1);
    imem_addr = 32'h3010;
    tick();
    chk("t1_wrong_path_oob", {31'b0, oob_err}, 32'd0);
    chk("t1_wrong_path_run", {31'b0, fetch_enable}, 32'd1);
    retire_end();
    chk("t1_done", {31'b0, done}, 32'd1);
    chk("t1_fetch_off", {31'b0, fetch_enable}, 32'd0);

    // Out-of-bounds fetches: past end, below base, misaligned, strict bound
    run_oob(4, 32'h3010);
    run_oob(4, 32'h2FFC);
    run_oob(4, 32'h3002);
    run_oob(3, 32'h300C);

    // Overflow: 6 words offered without last into a 4-word image
    imem_addr = TS;
    start();
    for (int i = 0; i < 6; i++) img[i] = 32'h1000 + i;
    load(6, 1'b0, 1'b0);
    chk("ovf_num_words", {29'b0, num_words}, 32'd4);
    chk("ovf_flag", {31'b0, load_ovf}, 32'd1);
    chk("ovf_ready", {31'b0, load_ready}, 32'd0);
    imem_addr = 32'h300C;
    #1;
    chk("ovf_word3", imem_rdata, 32'h1003);
    imem_addr = TS;
    retire_end();

    // Backpressure, reset mid-load, start+valid edge, reload from word 0
    start();
    load_valid = 1'b1; load_data = 32'hF0; tick();
    load_valid = 1'b0; tick();
    load_valid = 1'b1; load_data = 32'hF1; tick();
    load_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("bp_rst_ready", {31'b0, load_ready}, 32'd0);
    chk("bp_rst_words", {29'b0, num_words}, 32'd0);
    load_start = 1'b1; load_valid = 1'b1; load_data = 32'hBAD;
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    chk("start_edge_words", {29'b0, num_words}, 32'd0);
    chk("start_edge_ready", {31'b0, load_ready}, 32'd1);
    img[0] = 32'hA0; img[1] = 32'hA1; img[2] = 32'hA2; img[3] = EI;
    load(4, 1'b1, 1'b1);
    #1;
    chk("reload_word0", imem_rdata, 32'hA0);
    retire_end();

    // Cycle count: exactly 10 RUN cycles; ecall fetched and retired together
    start();
    img[0] = 32'h13; img[1] = EI;
    load(2, 1'b1, 1'b0);
    tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    repeat (7) tick();
    imem_addr = 32'h3004;
    retire_end();
    chk("cyc_ten", cycles, 32'd10);
    chk("cyc_done", {31'b0, done}, 32'd1);
    chk("cyc_prog_end", {31'b0, prog_end}, 32'd1);
    imem_addr = TS;
    tick();
    chk("cyc_held", cycles, 32'd10);
    start();
    chk("cyc_cleared", cycles, 32'd0);
    chk("cyc_pend_cleared", {31'b0, prog_end}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Synthesizable instruction-memory writer/responder that stands in for the bench-side instruction memory in front of the core's fetch port. A host streams a program image in over a valid/ready word interface. The block then releases fetch, serves the core's combinational instruction fetches from the loaded image, and flags out-of-bounds fetches. It ends the run when the core retires the end-of-test instruction (`ecall`).

## Interface
- `ADDR_WIDTH`, 12, log2 of image depth in 32-bit words (DEPTH = 2**ADDR_WIDTH)
- `TEXT_START`, 32'h0000_3000, byte address of image word 0
- `END_INSN`, 32'h0000_0073, end-of-test instruction encoding (`ecall`)
- `clk_i` in 1: clock, rising edge
- `rst_i` in 1: synchronous reset, active-high
- `load_start_i` in 1: begin a new load; honoured in IDLE and DONE only
- `load_data_i` in 32: program word
- `load_valid_i` in 1: `load_data_i` valid
- `load_last_i` in 1: current word is the final image word
- `load_ready_o` out 1: block accepts a word this cycle
- `imem_addr_i` in 32: core fetch byte address
- `imem_rdata_o` out 32: fetched instruction, combinational from `imem_addr_i`
- `retire_valid_i` in 1: core retired an instruction this cycle
- `retire_insn_i` in 32: encoding of the retired instruction
- `fetch_enable_o` out 1: core may fetch
- `prog_end_o` out 1: sticky; `END_INSN` has been fetched
- `oob_err_o` out 1: sticky; out-of-bounds fetch before `prog_end_o`
- `load_ovf_o` out 1: sticky; image filled DEPTH words without `load_last_i`
- `done_o` out 1: run finished
- `num_words_o` out ADDR_WIDTH+1: words loaded
- `cycles_o` out 32: cycles spent in RUN

## Operation
- **States:** IDLE, LOAD, RUN, DONE.
- **Output decode:** `load_ready_o` = (LOAD). `fetch_enable_o` = (RUN). `done_o` = (DONE). All three are decoded from the state register.
- **IDLE/DONE + `load_start_i`:**
  - Go to LOAD.
  - Clear `wr_ptr`, `num_words_o`, `cycles_o`, `prog_end_o`, `oob_err_o`, `load_ovf_o`.
  - Memory contents are not cleared.
- **`load_start_i` outside IDLE/DONE:** ignored.
- **LOAD:**
  - On `load_valid_i & load_ready_o`: write `mem[wr_ptr]`, increment `wr_ptr` and `num_words_o`.
  - Accepted word with `load_last_i`: go to RUN.
  - Accepted word at `wr_ptr == DEPTH-1` without `load_last_i`: treated as last; set `load_ovf_o`; go to RUN.
- **Fetch address check:**
  - `off = imem_addr_i - TEXT_START`, 32-bit modulo, so addresses below `TEXT_START` wrap large.
  - In range iff `off[1:0] == 0` and `off[31:2] < num_words_o`. The comparison is strict `<`.
- **`imem_rdata_o`:** `mem[off[ADDR_WIDTH+1:2]]` when `fetch_enable_o` is high and the address is in range; else 0.
- **RUN, in-range fetch with `imem_rdata_o == END_INSN`:** set `prog_end_o`.
- **RUN, out-of-range fetch with `prog_end_o` == 0:** set `oob_err_o`; go to DONE.
- **RUN, out-of-range fetch after `prog_end_o`:** legal wrong-path fetch. Return 0; no error.
- **RUN, `retire_valid_i & retire_insn_i == END_INSN`:** go to DONE.
- **`cycles_o`:** increments each RUN cycle; saturates at 32'hFFFF_FFFF.

## Timing
- **Reset:** `rst_i` sampled high at an edge gives state IDLE and clears `wr_ptr`, all flags, `num_words_o` and `cycles_o`.
  - Outputs after reset: `load_ready_o`=0, `fetch_enable_o`=0, `done_o`=0, `imem_rdata_o`=0.
  - Reset mid-LOAD or mid-RUN aborts immediately. Memory retains contents.
- **Load throughput:** one word per cycle. The write and the pointer update take effect at the accepting edge.
- **LOAD → RUN:** at the edge that accepts the last word. `fetch_enable_o` rises in the following cycle.
- **Start edge:** `load_start_i` and `load_valid_i` together in IDLE/DONE: start only. `load_ready_o` is 0 that cycle, so the word is not taken.
- **Fetch read:** zero-latency combinational read path, matching the core's fetch timing.
- **Flag timing:** `prog_end_o` and `oob_err_o` register at the edge following the qualifying fetch.
- **RUN → DONE:**
  - Retire of `END_INSN` takes effect at the retire edge.
  - `fetch_enable_o` falls in the next cycle.
  - `cycles_o` excludes the DONE cycles.
- **Simultaneous OOB fetch and `END_INSN` retire:** go to DONE. Set `oob_err_o` only if `prog_end_o` is 0.
- **Simultaneous `END_INSN` fetch and retire:** `prog_end_o` is set and the state goes to DONE.

## Configuration
- `IMEM_LOADER_OOB_CHECK_EN` defined: bounds checking, `oob_err_o`, and the OOB-induced DONE transition exist as described.
- `IMEM_LOADER_OOB_CHECK_EN` undefined:
  - Out-of-range fetches return 0.
  - `oob_err_o` is tied to 0.
  - RUN exits only on `END_INSN` retire or reset.

## Test plan
- **Load 4 words and run:** stream 4 words, last = `32'h0000_0073` with `load_last_i` on word 3 → `num_words_o`=4. Fetch `0x3000` returns word 0. Fetch `0x300C` returns `0x00000073` and sets `prog_end_o`. Retire of `0x73` → `done_o` one edge later, `fetch_enable_o`=0.
- **OOB fetch (check enabled):** 4-word image with no `ecall`; fetch `0x3010` → `imem_rdata_o`=0, `oob_err_o`=1, `done_o`=1. Fetch `0x2FFC` in a fresh run → same result. Fetch `0x3002` → same result.
- **Wrong-path after end:** after `prog_end_o`=1, fetch `0x3010` → `oob_err_o` stays 0; run continues until retire.
- **Overflow:** with `ADDR_WIDTH`=2, stream 6 words without `load_last_i` → 4 words accepted, `load_ovf_o`=1. RUN is entered after the 4th word; `load_ready_o`=0 for the remainder.
- **Backpressure and reset:** `load_valid_i` toggling, plus `rst_i` asserted after 2 accepted words → IDLE next cycle, `num_words_o`=0. A subsequent `load_start_i` reloads from word 0.
- **Cycle count:** RUN lasting exactly 10 cycles → `cycles_o`=10, held in DONE. The next `load_start_i` clears it to 0.
